// File: rtl/seq_encoder83.sv
// seq_encoder83: captures an 8-bit request vector and emits the index of
// each set bit, one per output handshake, in a fixed priority order.

// One scan lane: claims its bit when it is set and no higher-priority
// bit is pending. HIGHER is the elaboration-time mask of bits that win over it.
module seq_encoder83_lane #(
    parameter logic [7:0] HIGHER = 8'h00
) (
    input  logic       req,
    input  logic [7:0] pend,
    output logic       sel
);
    assign sel = req & ~(|(pend & HIGHER));
endmodule

module seq_encoder83 #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in_valid,
    input  logic [7:0] in_vec,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_code,
    output logic       out_last,
    output logic       err_zero
);
    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] code;
        logic       last;
    } rsp_t;

    state_t     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic       err_q, err_d;
    logic       live_q;     // low until the first edge after reset release
    logic [7:0] sel;        // one-hot: the bit that goes out next
    logic       single;     // exactly one bit left in pend
    logic [2:0] code_enc;
    rsp_t       rsp;

    // One lane per bit; priority masks fixed at elaboration.
    for (genvar i = 0; i < 8; i++) begin : g_lane
        localparam logic [7:0] HIGHER = LSB_FIRST ? 8'((8'd1 << i) - 8'd1)
                                                  : 8'(~((9'd2 << i) - 9'd1));
        seq_encoder83_lane #(.HIGHER(HIGHER)) u_lane (
            .req  (pend_q[i]),
            .pend (pend_q),
            .sel  (sel[i])
        );
    end

    // Binary-encode the one-hot selection.
    always_comb begin
        code_enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) code_enc = code_enc | 3'(i);
        end
    end

    assign single = (pend_q != 8'd0) && ((pend_q & (pend_q - 8'd1)) == 8'd0);

    // Outputs depend only on registered state; IDLE presents zeros.
    always_comb begin
        rsp       = '0;
        rsp.valid = (state_q == EMIT);
        if (state_q == EMIT) begin
            rsp.code = code_enc;
            rsp.last = single;
        end
    end

    assign out_valid = rsp.valid;
    assign out_code  = rsp.code;
    assign out_last  = rsp.last;
    assign in_ready  = live_q & (state_q == IDLE) & en;
    assign err_zero  = err_q;

    // Next-state: capture in IDLE, clear one bit per transfer in EMIT.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (in_vec != 8'd0) begin
                        pend_d  = in_vec;
                        state_d = EMIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pend_d = pend_q & ~sel;
                    if (single) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops everything, including any pending bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 8'd0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_encoder83.sv
// Directed bench for seq_encoder83: two instances (LSB-first and MSB-first)
// share all inputs; each task checks its own scenario.
module tb_seq_encoder83;
    logic       clk = 1'b0;
    logic       rst_n, en, in_valid, out_ready;
    logic [7:0] in_vec;
    logic       r1, v1, l1, e1, r0, v0, l0, e0;
    logic [2:0] c1, c0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_encoder83 #(.LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_vec(in_vec),
        .in_ready(r1), .out_valid(v1), .out_ready(out_ready), .out_code(c1),
        .out_last(l1), .err_zero(e1));

    seq_encoder83 #(.LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_vec(in_vec),
        .in_ready(r0), .out_valid(v0), .out_ready(out_ready), .out_code(c0),
        .out_last(l0), .err_zero(e0));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b1;
        #2;
        checks++;
        if ({r1, v1, c1, l1, e1} !== 7'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0000000", {r1, v1, c1, l1, e1});
        end
        step(); step();
        checks++;
        if (r1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_ready got=%b want=0", r1);
        end
        #2 rst_n = 1'b1;
        step();
        checks++;
        if (r1 !== 1'b1 || r0 !== 1'b1 || v1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got r1=%b r0=%b v1=%b want 1 1 0", r1, r0, v1);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_vec = 8'b0000_0100; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (v1 !== 1'b1 || c1 !== 3'd2 || l1 !== 1'b1 || r1 !== 1'b0) begin
            failures++;
            $display("FAIL single_emit got v=%b c=%0d l=%b r=%b want 1 2 1 0", v1, c1, l1, r1);
        end
        step();
        checks++;
        if (v1 !== 1'b0 || r1 !== 1'b1 || c1 !== 3'd0) begin
            failures++;
            $display("FAIL single_idle got v=%b r=%b c=%0d want 0 1 0", v1, r1, c1);
        end
    endtask

    task automatic test_lsb_order();
        logic [2:0] exp_c [3] = '{3'd1, 3'd4, 3'd7};
        logic       exp_l [3] = '{1'b0, 1'b0, 1'b1};
        in_valid = 1'b1; in_vec = 8'b1001_0010; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (v1 !== 1'b1 || c1 !== exp_c[i] || l1 !== exp_l[i]) begin
                failures++;
                $display("FAIL lsb_seq[%0d] got v=%b c=%0d l=%b want 1 %0d %b",
                         i, v1, c1, l1, exp_c[i], exp_l[i]);
            end
            step();
        end
        checks++;
        if (v1 !== 1'b0 || r1 !== 1'b1) begin
            failures++;
            $display("FAIL lsb_done got v=%b r=%b want 0 1", v1, r1);
        end
    endtask

    task automatic test_msb_stall();
        in_valid = 1'b1; in_vec = 8'b1001_0010; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (v0 !== 1'b1 || c0 !== 3'd7 || l0 !== 1'b0) begin
            failures++;
            $display("FAIL msb_first got v=%b c=%0d l=%b want 1 7 0", v0, c0, l0);
        end
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (v0 !== 1'b1 || c0 !== 3'd4 || l0 !== 1'b0) begin
                failures++;
                $display("FAIL msb_stall[%0d] got v=%b c=%0d l=%b want 1 4 0", i, v0, c0, l0);
            end
            step();
        end
        checks++;
        if (c0 !== 3'd4 || c1 !== 3'd4) begin
            failures++;
            $display("FAIL msb_stall_end got c0=%0d c1=%0d want 4 4", c0, c1);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (v0 !== 1'b1 || c0 !== 3'd1 || l0 !== 1'b1) begin
            failures++;
            $display("FAIL msb_last got v=%b c=%0d l=%b want 1 1 1", v0, c0, l0);
        end
        step();
        checks++;
        if (v0 !== 1'b0 || r0 !== 1'b1) begin
            failures++;
            $display("FAIL msb_done got v=%b r=%b want 0 1", v0, r0);
        end
    endtask

    task automatic test_zero();
        in_valid = 1'b1; in_vec = 8'h00;
        step();
        in_valid = 1'b0;
        checks++;
        if (e1 !== 1'b1 || v1 !== 1'b0 || r1 !== 1'b1) begin
            failures++;
            $display("FAIL zero_pulse got e=%b v=%b r=%b want 1 0 1", e1, v1, r1);
        end
        step();
        checks++;
        if (e1 !== 1'b0 || v1 !== 1'b0) begin
            failures++;
            $display("FAIL zero_clear got e=%b v=%b want 0 0", e1, v1);
        end
    endtask

    task automatic test_enable();
        en = 1'b0; in_valid = 1'b1; in_vec = 8'hFF;
        #1;
        checks++;
        if (r1 !== 1'b0) begin
            failures++;
            $display("FAIL en_low_ready got=%b want=0", r1);
        end
        step();
        checks++;
        if (v1 !== 1'b0 || v0 !== 1'b0) begin
            failures++;
            $display("FAIL en_low_accept got v1=%b v0=%b want 0 0", v1, v0);
        end
        en = 1'b1; in_vec = 8'h03;
        step();
        en = 1'b0; in_valid = 1'b0;
        checks++;
        if (v1 !== 1'b1 || c1 !== 3'd0 || l1 !== 1'b0) begin
            failures++;
            $display("FAIL en_emit0 got v=%b c=%0d l=%b want 1 0 0", v1, c1, l1);
        end
        step();
        checks++;
        if (v1 !== 1'b1 || c1 !== 3'd1 || l1 !== 1'b1) begin
            failures++;
            $display("FAIL en_emit1 got v=%b c=%0d l=%b want 1 1 1", v1, c1, l1);
        end
        step();
        checks++;
        if (v1 !== 1'b0 || r1 !== 1'b0) begin
            failures++;
            $display("FAIL en_idle got v=%b r=%b want 0 0", v1, r1);
        end
        en = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (v1 !== 1'b1 || c1 !== 3'(i)) begin
                failures++;
                $display("FAIL mid_pre[%0d] got v=%b c=%0d want 1 %0d", i, v1, c1, i);
            end
            if (i < 2) step();
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({r1, v1, c1, l1, e1, v0, c0} !== 11'd0) begin
            failures++;
            $display("FAIL mid_async got=%b want=0", {r1, v1, c1, l1, e1, v0, c0});
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (v1 !== 1'b0 || v0 !== 1'b0) begin
                failures++;
                $display("FAIL mid_discard[%0d] got v1=%b c1=%0d want v=0", i, v1, c1);
            end
        end
        in_valid = 1'b1; in_vec = 8'h80;
        step();
        in_valid = 1'b0;
        checks++;
        if (v1 !== 1'b1 || c1 !== 3'd7 || l1 !== 1'b1) begin
            failures++;
            $display("FAIL mid_fresh got v=%b c=%0d l=%b want 1 7 1", v1, c1, l1);
        end
        step();
        checks++;
        if (v1 !== 1'b0 || r1 !== 1'b1) begin
            failures++;
            $display("FAIL mid_fresh_done got v=%b r=%b want 0 1", v1, r1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_lsb_order();
        test_msb_stall();
        test_zero();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_encoder83.md
SEQ_ENCODER83 -- requirements
Module: seq_encoder83

Interface
REQ-001 Parameter: LSB_FIRST, default 1, scan order (1: bit 0 highest priority; 0: bit 7 highest priority).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 en  input  1  acceptance enable; gates input handshake only.
REQ-005 in_valid  input  1  in_vec valid.
REQ-006 in_vec  input  8  one-hot or multi-hot request vector.
REQ-007 in_ready  output  1  block can accept in_vec this cycle.
REQ-008 out_valid  output  1  out_code valid.
REQ-009 out_ready  input  1  downstream accepts out_code this cycle.
REQ-010 out_code  output  3  binary index of currently selected set bit.
REQ-011 out_last  output  1  current out_code is final code for captured vector.
REQ-012 err_zero  output  1  one-cycle pulse: all-zero vector accepted.

Function
REQ-013 Block SHALL encode every set bit of an accepted 8-bit vector into 3-bit indices, one index per output transfer, in priority order per LSB_FIRST.
REQ-014 States SHALL be IDLE and EMIT only; internal 8-bit register pend holds unsent bits.
REQ-015 IDLE: in_ready SHALL equal en; out_valid SHALL be 0.
REQ-016 EMIT: in_ready SHALL be 0; out_valid SHALL be 1.
REQ-017 Input transfer: in_valid & in_ready at a rising edge.
REQ-018 Input transfer with in_vec != 0: pend <= in_vec, state -> EMIT; out_valid high in the very next cycle (latency 1 clock).
REQ-019 Input transfer with in_vec == 0: state stays IDLE, pend unchanged (0), err_zero = 1 for exactly the next cycle, no output transfer generated.
REQ-020 In EMIT, out_code SHALL be the index of the highest-priority set bit of pend (LSB_FIRST=1: lowest index; 0: highest index).
REQ-021 In EMIT, out_last SHALL be 1 iff pend has exactly one bit set; 0 otherwise and 0 in IDLE.
REQ-022 out_code, out_last SHALL be functions of registered state only (no combinational path from any input).
REQ-023 Output transfer: out_valid & out_ready at a rising edge; the selected bit of pend SHALL clear.
REQ-024 Output transfer with out_last=1: state -> IDLE; in_ready may rise next cycle (one bubble; no same-cycle reload).
REQ-025 out_valid=1 with out_ready=0: out_code, out_last, state, pend SHALL hold unchanged indefinitely.
REQ-026 en deasserted during EMIT SHALL NOT stall emission; it only blocks the next acceptance.
REQ-027 in_vec and in_valid SHALL be ignored whenever in_ready=0.
REQ-028 In IDLE, out_code SHALL be 3'b000.
REQ-029 Throughput: vector with k set bits occupies k EMIT cycles minimum plus one IDLE cycle.

Reset
REQ-030 rst_n low SHALL immediately (asynchronously) force state=IDLE, pend=0, out_valid=0, out_last=0, out_code=0, err_zero=0, in_ready=0.
REQ-031 in_ready SHALL remain 0 while rst_n low; after release, in_ready=en from first rising edge.
REQ-032 Reset asserted mid-EMIT SHALL discard remaining bits; no code from that vector emitted after release.

Verification
REQ-033 LSB_FIRST=1, en=1, in_vec=8'b0000_0100, out_ready=1 -> one cycle later out_valid=1, out_code=3'd2, out_last=1; next cycle IDLE, in_ready=1.
REQ-034 LSB_FIRST=1, in_vec=8'b1001_0010, out_ready=1 -> out_code sequence 1,4,7 on consecutive cycles, out_last=1 only with 7.
REQ-035 LSB_FIRST=0, in_vec=8'b1001_0010 -> sequence 7,4,1; out_ready held 0 for 3 cycles at code 4 -> code 4 held stable, no skip.
REQ-036 in_vec=8'h00 accepted -> err_zero pulses 1 cycle, out_valid stays 0, in_ready stays 1.
REQ-037 en=0 in IDLE with in_valid=1, in_vec=8'hFF -> in_ready=0, no acceptance; en=0 during EMIT of 8'h03 -> codes 0,1 still emitted.
REQ-038 rst_n pulsed low between edges while emitting 8'hFF after code 2 -> outputs zero immediately; after release no codes 3..7 appear, fresh 8'h80 yields code 7.
